axi_rd_arbiter: RTL and testbench

- Shares the single AXI read channel (AR/R) between the instruction fetch unit (IFU) and the load/store unit (LSU) of the EXU.
- Sits between both masters and the memory-side AXI port. The LSU write channels (AW/W/B) bypass this block.
- One outstanding read at a time, single-beat transfers, round-robin arbitration on contention.

---
 rtl/axi_arb_pkg.sv | 19 +
 rtl/arb_rr2.sv | 31 +++
 rtl/axi_rd_arbiter.sv | 160 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// ----------------------------------------------------------------------------
// axi_arb_pkg
//   Shared types and constants for the AXI read-channel arbiter.
//   arb_state_e : FSM encoding (IDLE -> address phase -> data phase)
//   OWN_IFU     : one-hot owner code for the instruction fetch unit
//   OWN_LSU     : one-hot owner code for the load/store unit
// ----------------------------------------------------------------------------
package axi_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_AR   = 2'd1,
      ARB_R    = 2'd2
   } arb_state_e;

   localparam logic [1:0] OWN_IFU = 2'b01;
   localparam logic [1:0] OWN_LSU = 2'b10;

endpackage

// File: rtl/arb_rr2.sv
// ----------------------------------------------------------------------------
// arb_rr2
//   Combinational 2-way round-robin picker.
//   req[1:0]   in  : request vector, [0]=IFU, [1]=LSU
//   last_grant in  : previous winner, 0=IFU, 1=LSU
//   gnt[1:0]   out : one-hot grant (OWN_IFU / OWN_LSU), 0 if no request
//   any        out : at least one request is pending
// ----------------------------------------------------------------------------
module arb_rr2
   import axi_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt,
   output logic       any
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = OWN_IFU;
         2'b10:   gnt = OWN_LSU;
         // On contention the master that did not win last time goes first.
         2'b11:   gnt = last_grant ? OWN_IFU : OWN_LSU;
         default: gnt = 2'b00;
      endcase
   end

   assign any = |req;

endmodule

// File: rtl/axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter
//   Shares one AXI read channel (AR/R) between the IFU and the LSU.
//   One outstanding single-beat read at a time, round-robin on contention.
//   clk, rst_n           : clock, async active-low reset
//   ifu_AR_* / ifu_R_*   : IFU read master port
//   lsu_AR_* / lsu_R_*   : LSU read master port
//   mem_AR_* / mem_R_*   : memory-side read port
//   arb_busy             : a transaction is in progress (state != IDLE)
//   arb_owner            : one-hot owner, [0]=IFU, [1]=LSU, 0 when idle
// ----------------------------------------------------------------------------
module axi_rd_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ifu_AR_ADDR,
   input  logic              ifu_AR_VALID,
   output logic              ifu_AR_READY,
   output logic [DATA_W-1:0] ifu_R_DATA,
   output logic              ifu_R_VALID,
   input  logic              ifu_R_READY,
   input  logic [ADDR_W-1:0] lsu_AR_ADDR,
   input  logic              lsu_AR_VALID,
   output logic              lsu_AR_READY,
   output logic [DATA_W-1:0] lsu_R_DATA,
   output logic              lsu_R_VALID,
   input  logic              lsu_R_READY,
   output logic [ADDR_W-1:0] mem_AR_ADDR,
   output logic              mem_AR_VALID,
   input  logic              mem_AR_READY,
   input  logic [DATA_W-1:0] mem_R_DATA,
   input  logic              mem_R_VALID,
   output logic              mem_R_READY,
   output logic              arb_busy,
   output logic [1:0]        arb_owner
);

   arb_state_e r_state, w_state_nxt;
   logic [1:0] r_owner, w_owner_nxt;
   logic       r_last_grant, w_last_nxt;

   logic [1:0] w_gnt;
   logic       w_any;
   logic       w_own_ifu, w_own_lsu;
   logic       w_ar_hs, w_r_hs;

   arb_rr2 u_rr (
      .req        ({lsu_AR_VALID, ifu_AR_VALID}),
      .last_grant (r_last_grant),
      .gnt        (w_gnt),
      .any        (w_any)
   );

   assign w_own_ifu = r_owner[0];
   assign w_own_lsu = r_owner[1];

   // Both handshakes are already qualified by state through the output mux.
   assign w_ar_hs = mem_AR_VALID & mem_AR_READY;
   assign w_r_hs  = mem_R_VALID  & mem_R_READY;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ARB_IDLE;
         r_owner      <= 2'b00;
         r_last_grant <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_grant <= w_last_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last_grant;
      case (r_state)
         ARB_IDLE: begin
            if (w_any) begin
               w_state_nxt = ARB_AR;
               w_owner_nxt = w_gnt;
               w_last_nxt  = w_gnt[1];
            end
         end
         // A dropped AR_VALID here is a protocol error; we simply wait.
         ARB_AR: begin
            if (w_ar_hs) w_state_nxt = ARB_R;
         end
         ARB_R: begin
            if (w_r_hs) begin
               w_state_nxt = ARB_IDLE;
               w_owner_nxt = 2'b00;
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
            w_owner_nxt = 2'b00;
         end
      endcase
   end

   // Channel muxing. Everything is zero in IDLE, so there is no
   // combinational path from a master's AR_VALID to its AR_READY there.
   always_comb begin
      mem_AR_ADDR  = '0;
      mem_AR_VALID = 1'b0;
      ifu_AR_READY = 1'b0;
      lsu_AR_READY = 1'b0;
      ifu_R_DATA   = '0;
      ifu_R_VALID  = 1'b0;
      lsu_R_DATA   = '0;
      lsu_R_VALID  = 1'b0;
      mem_R_READY  = 1'b0;
      case (r_state)
         ARB_AR: begin
            if (w_own_ifu) begin
               mem_AR_ADDR  = ifu_AR_ADDR;
               mem_AR_VALID = ifu_AR_VALID;
               ifu_AR_READY = mem_AR_READY;
            end else if (w_own_lsu) begin
               mem_AR_ADDR  = lsu_AR_ADDR;
               mem_AR_VALID = lsu_AR_VALID;
               lsu_AR_READY = mem_AR_READY;
            end
         end
         ARB_R: begin
            if (w_own_ifu) begin
               ifu_R_DATA  = mem_R_DATA;
               ifu_R_VALID = mem_R_VALID;
               mem_R_READY = ifu_R_READY;
            end else if (w_own_lsu) begin
               lsu_R_DATA  = mem_R_DATA;
               lsu_R_VALID = mem_R_VALID;
               mem_R_READY = lsu_R_READY;
            end
         end
         default: ;
      endcase
   end

   assign arb_busy  = (r_state != ARB_IDLE);
   assign arb_owner = r_owner;

   // Protocol monitors (simulation only; ignored by synthesis).
   always @(posedge clk) begin
      if (rst_n) begin
         if (r_state == ARB_AR)
            assert (mem_AR_VALID)
               else $error("axi_rd_arbiter: owner dropped AR_VALID before address handshake");
         if (r_state != ARB_R)
            assert (!mem_R_VALID)
               else $error("axi_rd_arbiter: mem_R_VALID asserted outside data phase");
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
   import axi_arb_pkg::*;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] ifu_AR_ADDR;
   logic              ifu_AR_VALID;
   logic              ifu_AR_READY;
   logic [DATA_W-1:0] ifu_R_DATA;
   logic              ifu_R_VALID;
   logic              ifu_R_READY;
   logic [ADDR_W-1:0] lsu_AR_ADDR;
   logic              lsu_AR_VALID;
   logic              lsu_AR_READY;
   logic [DATA_W-1:0] lsu_R_DATA;
   logic              lsu_R_VALID;
   logic              lsu_R_READY;
   logic [ADDR_W-1:0] mem_AR_ADDR;
   logic              mem_AR_VALID;
   logic              mem_AR_READY;
   logic [DATA_W-1:0] mem_R_DATA;
   logic              mem_R_VALID;
   logic              mem_R_READY;
   logic              arb_busy;
   logic [1:0]        arb_owner;

   int n_cmp = 0;
   int n_err = 0;

   axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ifu_AR_ADDR  (ifu_AR_ADDR),
      .ifu_AR_VALID (ifu_AR_VALID),
      .ifu_AR_READY (ifu_AR_READY),
      .ifu_R_DATA   (ifu_R_DATA),
      .ifu_R_VALID  (ifu_R_VALID),
      .ifu_R_READY  (ifu_R_READY),
      .lsu_AR_ADDR  (lsu_AR_ADDR),
      .lsu_AR_VALID (lsu_AR_VALID),
      .lsu_AR_READY (lsu_AR_READY),
      .lsu_R_DATA   (lsu_R_DATA),
      .lsu_R_VALID  (lsu_R_VALID),
      .lsu_R_READY  (lsu_R_READY),
      .mem_AR_ADDR  (mem_AR_ADDR),
      .mem_AR_VALID (mem_AR_VALID),
      .mem_AR_READY (mem_AR_READY),
      .mem_R_DATA   (mem_R_DATA),
      .mem_R_VALID  (mem_R_VALID),
      .mem_R_READY  (mem_R_READY),
      .arb_busy     (arb_busy),
      .arb_owner    (arb_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
         else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0]  exp_own;
      logic [63:0] exp_addr;

      rst_n        = 1'b0;
      ifu_AR_ADDR  = '0;
      ifu_AR_VALID = 1'b0;
      ifu_R_READY  = 1'b0;
      lsu_AR_ADDR  = '0;
      lsu_AR_VALID = 1'b0;
      lsu_R_READY  = 1'b0;
      mem_AR_READY = 1'b0;
      mem_R_DATA   = '0;
      mem_R_VALID  = 1'b0;

      // ---------------- reset state ----------------
      #2;
      chk("rst_busy",      arb_busy,     0);
      chk("rst_owner",     arb_owner,    0);
      chk("rst_mem_arv",   mem_AR_VALID, 0);
      chk("rst_mem_addr",  mem_AR_ADDR,  0);
      chk("rst_mem_rrdy",  mem_R_READY,  0);
      step();
      step();
      rst_n = 1'b1;

      // ---------------- contention right after reset: LSU, IFU, LSU, IFU ----
      ifu_AR_ADDR  = 64'h8000_0000;
      lsu_AR_ADDR  = 64'h8000_1000;
      ifu_AR_VALID = 1'b1;
      lsu_AR_VALID = 1'b1;
      mem_AR_READY = 1'b1;
      ifu_R_READY  = 1'b1;
      lsu_R_READY  = 1'b1;
      #1;
      chk("idle_no_arv",   mem_AR_VALID, 0);
      chk("idle_ifu_rdy",  ifu_AR_READY, 0);
      chk("idle_lsu_rdy",  lsu_AR_READY, 0);
      for (int k = 0; k < 4; k++) begin
         exp_own  = (k % 2 == 0) ? 2'b10 : 2'b01;
         exp_addr = (k % 2 == 0) ? 64'h8000_1000 : 64'h8000_0000;
         step();   // grant decided -> ARB_AR
         chk($sformatf("rr%0d_owner", k), arb_owner,   exp_own);
         chk($sformatf("rr%0d_addr", k),  mem_AR_ADDR, exp_addr);
         chk($sformatf("rr%0d_arv", k),   mem_AR_VALID, 1);
         chk($sformatf("rr%0d_lsurdy", k), lsu_AR_READY, exp_own[1]);
         chk($sformatf("rr%0d_ifurdy", k), ifu_AR_READY, exp_own[0]);
         step();   // address handshake -> ARB_R
         mem_R_VALID = 1'b1;
         mem_R_DATA  = 64'h1000 + 64'(k);
         #1;
         chk($sformatf("rr%0d_r_arv", k),  mem_AR_VALID, 0);
         chk($sformatf("rr%0d_ifurv", k),  ifu_R_VALID, exp_own[0]);
         chk($sformatf("rr%0d_lsurv", k),  lsu_R_VALID, exp_own[1]);
         chk($sformatf("rr%0d_data", k),
             exp_own[0] ? ifu_R_DATA : lsu_R_DATA, 64'h1000 + 64'(k));
         step();   // data handshake -> ARB_IDLE
         mem_R_VALID = 1'b0;
         if (k == 3) begin
            ifu_AR_VALID = 1'b0;
            lsu_AR_VALID = 1'b0;
         end
         #1;
         chk($sformatf("rr%0d_idle", k),   arb_busy, 0);
      end

      // ---------------- single IFU read ----------------
      step();
      chk("quiet_idle", arb_busy, 0);
      ifu_AR_ADDR  = 64'h8000_0000;
      ifu_AR_VALID = 1'b1;
      #1;
      chk("s_idle_rdy", ifu_AR_READY, 0);
      step();
      chk("s_arv",      mem_AR_VALID, 1);
      chk("s_addr",     mem_AR_ADDR,  64'h8000_0000);
      chk("s_owner",    arb_owner,    OWN_IFU);
      chk("s_ifurdy",   ifu_AR_READY, 1);
      step();
      ifu_AR_VALID = 1'b0;
      mem_R_VALID  = 1'b1;
      mem_R_DATA   = 64'hDEAD_BEEF;
      #1;
      chk("s_ifurv",    ifu_R_VALID,  1);
      chk("s_ifudata",  ifu_R_DATA,   64'hDEAD_BEEF);
      chk("s_lsurv",    lsu_R_VALID,  0);
      chk("s_lsudata",  lsu_R_DATA,   0);
      chk("s_owner_r",  arb_owner,    OWN_IFU);
      step();
      mem_R_VALID = 1'b0;
      #1;
      chk("s_done_busy",  arb_busy,  0);
      chk("s_done_owner", arb_owner, 0);

      // ---------------- stalled memory (LSU wins, IFU waits) ----------------
      lsu_AR_ADDR  = 64'h8000_2000;
      lsu_AR_VALID = 1'b1;
      ifu_AR_VALID = 1'b1;
      mem_AR_READY = 1'b0;
      lsu_R_READY  = 1'b0;
      step();
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("st%0d_arv", c),    mem_AR_VALID, 1);
         chk($sformatf("st%0d_addr", c),   mem_AR_ADDR,  64'h8000_2000);
         chk($sformatf("st%0d_ifurdy", c), ifu_AR_READY, 0);
         step();
      end
      mem_AR_READY = 1'b1;
      #1;
      chk("st5_arv",    mem_AR_VALID, 1);
      chk("st5_addr",   mem_AR_ADDR,  64'h8000_2000);
      chk("st5_lsurdy", lsu_AR_READY, 1);
      chk("st5_ifurdy", ifu_AR_READY, 0);
      step();
      lsu_AR_VALID = 1'b0;

      // ---------------- R backpressure, IFU late request pending ----------
      mem_R_VALID = 1'b1;
      mem_R_DATA  = 64'hCAFE;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp%0d_rrdy", c),   mem_R_READY,  0);
         chk($sformatf("bp%0d_busy", c),   arb_busy,     1);
         chk($sformatf("bp%0d_lsurv", c),  lsu_R_VALID,  1);
         chk($sformatf("bp%0d_ifurv", c),  ifu_R_VALID,  0);
         chk($sformatf("bp%0d_ifurdy", c), ifu_AR_READY, 0);
         chk($sformatf("bp%0d_arv", c),    mem_AR_VALID, 0);
         step();
      end
      lsu_R_READY = 1'b1;
      #1;
      chk("bp_rrdy",    mem_R_READY, 1);
      chk("bp_data",    lsu_R_DATA,  64'hCAFE);
      step();
      mem_R_VALID = 1'b0;
      #1;
      chk("bp_idle",    arb_busy,     0);
      chk("late_idle_rdy", ifu_AR_READY, 0);
      step();
      chk("late_arv",   mem_AR_VALID, 1);
      chk("late_owner", arb_owner,    OWN_IFU);
      chk("late_addr",  mem_AR_ADDR,  64'h8000_0000);
      step();
      ifu_AR_VALID = 1'b0;

      // ---------------- reset in the data phase ----------------
      ifu_R_READY = 1'b0;
      mem_R_VALID = 1'b1;
      mem_R_DATA  = 64'h5555;
      #1;
      chk("pre_rst_rv", ifu_R_VALID, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",  arb_busy,     0);
      chk("mid_rst_owner", arb_owner,    0);
      chk("mid_rst_rv",    ifu_R_VALID,  0);
      chk("mid_rst_rdata", ifu_R_DATA,   0);
      chk("mid_rst_rrdy",  mem_R_READY,  0);
      chk("mid_rst_arv",   mem_AR_VALID, 0);
      mem_R_VALID = 1'b0;
      step();
      rst_n       = 1'b1;
      ifu_R_READY = 1'b1;
      ifu_AR_ADDR = 64'h8000_4000;
      ifu_AR_VALID = 1'b1;
      step();
      chk("post_owner", arb_owner,    OWN_IFU);
      chk("post_addr",  mem_AR_ADDR,  64'h8000_4000);
      chk("post_ardy",  ifu_AR_READY, 1);
      step();
      ifu_AR_VALID = 1'b0;
      mem_R_VALID  = 1'b1;
      mem_R_DATA   = 64'h7777;
      #1;
      chk("post_data",  ifu_R_DATA,  64'h7777);
      step();
      mem_R_VALID = 1'b0;
      #1;
      chk("post_idle",  arb_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
